// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/hold control for load-use, taken-branch and data-memory wait hazards
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_id,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use, mem_stall, hold_cycle;

    assign load_use   = memread_ex && rd_ex != 5'd31 && (rd_ex == inst_id[9:5] || rd_ex == inst_id[20:16]);
    assign mem_stall  = dmem_req && !dmem_ready;
    assign hold_cycle = (state_q == RUN && mem_stall) || (state_q == MEM_WAIT && !dmem_ready) || state_q == ERROR;
    assign mem_err     = state_q == ERROR;
    assign stall_count = stall_q;

    // Pipeline control: reset forces a bubble, memory hold beats branch flush beats load-use stall
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hold_cycle) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Next state, wait-cycle counter and saturating stall counter
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        stall_d = (!pc_write && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == 8'(MEM_TIMEOUT)) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end
endmodule
